pdm_pcm_packer: RTL and testbench

- Downstream stage of the PDM front end.
- Receives the 16-bit PCM sample stream that the CIC decimator emits in channel-interleaved order (ch0, ch1[, ch2, ch3], ch0, ...). That stream has no backpressure.
- Tags each sample with its channel, optionally packs two 16-bit samples into one 32-bit word, and buffers the words in a small FIFO.
- Feeds the uDMA RX channel through a valid/ready interface and flags overflow when the buffer cannot absorb a word.

---
 rtl/pdm_pcm_packer_if.sv | 10 +
 rtl/pdm_pcm_packer.sv | 112 +++++++++++
 tb/tb_pdm_pcm_packer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pdm_pcm_packer_if.sv
// Word stream from the PCM packer to the uDMA RX channel (valid/ready).
interface pdm_pcm_packer_if;
  logic [31:0] data;
  logic [1:0]  ch;
  logic        valid;
  logic        ready;

  modport master (output data, ch, valid, input ready);
  modport slave  (input data, ch, valid, output ready);
endinterface

// File: rtl/pdm_pcm_packer.sv
// Tags channel-interleaved PCM samples, optionally packs sample pairs into
// 32-bit words and buffers them in a FWFT FIFO toward the uDMA.
module pdm_pcm_packer #(
  parameter  int FIFO_DEPTH = 4,
  localparam int LOG_DEPTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [1:0]           cfg_ch_num_i,
  input  logic                 cfg_pack_i,
  input  logic                 cfg_clr_i,
  input  logic [15:0]          pcm_data_i,
  input  logic                 pcm_data_valid_i,
  pdm_pcm_packer_if.master     rx,
  output logic                 overflow_o,
  output logic [LOG_DEPTH:0]   level_o
);

  localparam logic [LOG_DEPTH:0] FULL_LVL = (LOG_DEPTH + 1)'(FIFO_DEPTH);

  function automatic logic [31:0] sext16(input logic signed [15:0] s);
    return 32'(s);
  endfunction

  logic [1:0]           ch_cnt_q, ch_cnt_d, ch_last;
  logic                 phase_q, phase_d;
  logic [15:0]          hold_q;
  logic [1:0]           hold_ch_q;
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          mem_data_q [FIFO_DEPTH];
  logic [1:0]           mem_ch_q   [FIFO_DEPTH];

  logic        smp, push, pop, full, accept, drop, valid;
  logic [31:0] push_data;
  logic [1:0]  push_ch;

  always_comb begin
    ch_last   = (cfg_ch_num_i == 2'd2) ? 2'd3 : cfg_ch_num_i;
    smp       = cfg_en_i & pcm_data_valid_i;
    push      = smp & (~cfg_pack_i | phase_q);
    push_data = cfg_pack_i ? {pcm_data_i, hold_q} : sext16(pcm_data_i);
    push_ch   = cfg_pack_i ? hold_ch_q : ch_cnt_q;
    valid     = cfg_en_i & (level_q != '0);
    pop       = valid & rx.ready;
    full      = (level_q == FULL_LVL);
    // A full FIFO still takes a word when a slot frees up in the same cycle
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;

    ch_cnt_d = ch_cnt_q;
    phase_d  = phase_q;
    if (smp) begin
      ch_cnt_d = (ch_cnt_q == ch_last) ? 2'd0 : ch_cnt_q + 2'd1;
      // Pairing restarts on channel wrap, except in 1-channel mode
      phase_d  = ~phase_q & ((ch_cnt_d != 2'd0) | (ch_last == 2'd0));
    end

    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (accept & ~pop)      level_d = level_q + 1'b1;
    else if (~accept & pop) level_d = level_q - 1'b1;
    ovf_d = drop | (ovf_q & ~cfg_clr_i);

    if (!cfg_en_i) begin
      ch_cnt_d = '0;
      phase_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_cnt_q <= '0;
      phase_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_ch_q[wr_ptr_q]   <= push_ch;
    end
    if (smp & cfg_pack_i & ~phase_q) begin
      hold_q    <= pcm_data_i;
      hold_ch_q <= ch_cnt_q;
    end
  end

  assign rx.valid   = valid;
  assign rx.data    = valid ? mem_data_q[rd_ptr_q] : '0;
  assign rx.ch      = valid ? mem_ch_q[rd_ptr_q]   : '0;
  assign overflow_o = ovf_q;
  assign level_o    = cfg_en_i ? level_q : '0;

endmodule

// File: tb/tb_pdm_pcm_packer.sv
// Bench for pdm_pcm_packer: directed test-plan steps plus randomized traffic
// against a queue-based reference model.
module tb_pdm_pcm_packer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, en, pack, clr, pv;
  logic [1:0]  chn;
  logic [15:0] pd;
  logic        ovf;
  logic [2:0]  lvl;

  always #5 clk = ~clk;

  pdm_pcm_packer_if bus();

  pdm_pcm_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(en), .cfg_ch_num_i(chn),
    .cfg_pack_i(pack), .cfg_clr_i(clr), .pcm_data_i(pd),
    .pcm_data_valid_i(pv), .rx(bus), .overflow_o(ovf), .level_o(lvl)
  );

  // Reference model: words as {ch, data}; k counts samples since enable
  logic [33:0] q[$];
  int          k;
  logic        m_ovf;
  logic [17:0] m_hold;
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nch();
    return (chn == 2'd2) ? 4 : int'(chn) + 1;
  endfunction

  task automatic check_outs();
    logic mv;
    mv = en && (q.size() > 0);
    chk("valid", 34'(bus.valid), 34'(mv));
    chk("level", 34'(lvl), en ? 34'(q.size()) : 34'd0);
    chk("overflow", 34'(ovf), 34'(m_ovf));
    if (mv) begin
      chk("data", 34'(bus.data), 34'(q[0][31:0]));
      chk("ch", 34'(bus.ch), 34'(q[0][33:32]));
    end
  endtask

  task automatic model_update();
    logic [33:0] w;
    logic        pw, drop;
    int          n;
    n  = nch();
    pw = 1'b0;
    w  = '0;
    if (!en) begin
      q.delete();
      k = 0;
      m_ovf = m_ovf & ~clr;
      return;
    end
    if (bus.ready && q.size() > 0) void'(q.pop_front());
    if (pv) begin
      if (!pack) begin
        w  = {2'(k % n), {16{pd[15]}}, pd};
        pw = 1'b1;
      end else if (k % 2 == 0) begin
        m_hold = {2'(k % n), pd};
      end else begin
        w  = {m_hold[17:16], pd, m_hold[15:0]};
        pw = 1'b1;
      end
      k++;
    end
    drop = pw && (q.size() >= DEPTH);
    if (pw && !drop) q.push_back(w);
    m_ovf = drop | (m_ovf & ~clr);
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic rdy, input logic c = 1'b0);
    pv = v; pd = d; bus.ready = rdy; clr = c;
    @(negedge clk);
    check_outs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [1:0] c, input logic p);
    en = 1'b0; chn = c; pack = p;
    step(1'b0, 16'h0, 1'b0);
    en = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; en = 1'b0; chn = 2'd0; pack = 1'b0; clr = 1'b0;
    pv = 1'b0; pd = 16'h0; bus.ready = 1'b0;
    k = 0; m_ovf = 1'b0; m_hold = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 34'(bus.valid), 34'd0);
    chk("rst_data", 34'(bus.data), 34'd0);
    chk("rst_ch", 34'(bus.ch), 34'd0);
    chk("rst_ovf", 34'(ovf), 34'd0);
    chk("rst_level", 34'(lvl), 34'd0);
    rst = 1'b0;

    // 1 channel, unpacked
    configure(2'd0, 1'b0);
    step(1'b1, 16'h8001, 1'b1);
    chk("tp1_w0", {bus.ch, bus.data}, {2'd0, 32'hFFFF8001});
    step(1'b1, 16'h0002, 1'b1);
    chk("tp1_w1", {bus.ch, bus.data}, {2'd0, 32'h00000002});
    step(1'b0, 16'h0, 1'b1);

    // 2 channels, packed
    configure(2'd1, 1'b1);
    step(1'b1, 16'h1111, 1'b1);
    chk("tp2_noword_a", 34'(bus.valid), 34'd0);
    step(1'b1, 16'h2222, 1'b1);
    chk("tp2_w0", {bus.ch, bus.data}, {2'd0, 32'h22221111});
    step(1'b1, 16'h3333, 1'b1);
    chk("tp2_noword_c", 34'(bus.valid), 34'd0);
    step(1'b1, 16'h4444, 1'b1);
    chk("tp2_w1", {bus.ch, bus.data}, {2'd0, 32'h44443333});
    step(1'b0, 16'h0, 1'b1);

    // 4 channels, unpacked
    configure(2'd3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'(16'h0010 + i), 1'b1);
      chk("tp3_ch", 34'(bus.ch), 34'(i % 4));
    end
    step(1'b0, 16'h0, 1'b1);

    // Overflow, drain, clear
    configure(2'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    chk("tp4_level", 34'(lvl), 34'd4);
    chk("tp4_ovf", 34'(ovf), 34'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("tp4_clr", 34'(ovf), 34'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0200 + i), 1'b0);
    chk("tp5_full", 34'(lvl), 34'd4);
    step(1'b1, 16'h0204, 1'b1);
    chk("tp5_level", 34'(lvl), 34'd4);
    chk("tp5_ovf", 34'(ovf), 34'd0);
    chk("tp5_head", 34'(bus.data), 34'h0201);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);

    // Disable with a half-filled pair, then resume
    configure(2'd1, 1'b1);
    step(1'b1, 16'h5555, 1'b1);
    en = 1'b0;
    step(1'b1, 16'h6666, 1'b1);
    en = 1'b1;
    step(1'b1, 16'hAAAA, 1'b1);
    step(1'b1, 16'hBBBB, 1'b1);
    chk("tp6_word", {bus.ch, bus.data}, {2'd0, 32'hBBBBAAAA});
    step(1'b0, 16'h0, 1'b1);

    // Asynchronous reset in the middle of traffic
    configure(2'd0, 1'b0);
    step(1'b1, 16'h0300, 1'b0);
    step(1'b1, 16'h0301, 1'b0);
    rst = 1'b1;
    #2;
    chk("arst_valid", 34'(bus.valid), 34'd0);
    chk("arst_level", 34'(lvl), 34'd0);
    q.delete(); k = 0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b1);

    // Randomized traffic over every channel/pack configuration
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 2; p++) begin
        configure(2'(c), 1'(p));
        repeat (150)
          step(1'($urandom_range(0, 1)), 16'($urandom),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 30) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
